// File: rtl/decoder_scan_nxm_pkg.sv
// Shared state and mode definitions for the decoder_scan_nxm line decoder.
package decoder_scan_nxm_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BLANK  = 2'd1,
      DIRECT = 2'd2,
      SCAN   = 2'd3
   } state_e;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/decoder_scan_nxm_if.sv
// Control, address handshake and line outputs of decoder_scan_nxm.
interface decoder_scan_nxm_if #(
   parameter int unsigned N     = 4,
   parameter int unsigned LINES = 1 << N
);
   logic             en;
   logic             mode;
   logic             in_valid;
   logic             in_ready;
   logic [N-1:0]     in_addr;
   logic [LINES-1:0] out;
   logic [N-1:0]     active_idx;
   logic             step;
   logic             err;

   modport master (
      output en, mode, in_valid, in_addr,
      input  in_ready, out, active_idx, step, err
   );

   modport slave (
      input  en, mode, in_valid, in_addr,
      output in_ready, out, active_idx, step, err
   );
endinterface

// File: rtl/decoder_scan_nxm_scan_prescaler.sv
// Terminal-count prescaler for scan stepping; flags are registered from the next count.
// With DECODER_BBM_EN it also flags the cycle before terminal count.
module decoder_scan_nxm_scan_prescaler #(
   parameter int unsigned PRESCALE = 1000,
   parameter int unsigned CW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic tc
`ifdef DECODER_BBM_EN
   ,
   output logic pre_tc
`endif
);
   localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CW'(1);
      end
   end

   // Flags describe the count that will be held after this edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         tc     <= (LAST == '0);
`ifdef DECODER_BBM_EN
         pre_tc <= (CW'(PRESCALE - 2) == '0);
`endif
      end else begin
         cnt_q  <= cnt_d;
         tc     <= (cnt_d == LAST);
`ifdef DECODER_BBM_EN
         pre_tc <= (cnt_d == CW'(PRESCALE - 2));
`endif
      end
   end

endmodule

// File: rtl/decoder_scan_nxm.sv
// Registered N-to-LINES one-hot line decoder with direct (handshake) and scan modes.
// Define DECODER_BBM_EN for break-before-make: one all-zero cycle between different lines.
module decoder_scan_nxm
   import decoder_scan_nxm_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned LINES    = 1 << N,
   parameter int unsigned PRESCALE = 1000
) (
   input logic               clk,
   input logic               rst_n,
   decoder_scan_nxm_if.slave bus
);
   localparam logic [N-1:0] LAST_IDX = N'(LINES - 1);

   if (LINES < 2 || LINES > (1 << N)) begin : g_lines_chk
      $error("decoder_scan_nxm: LINES must be within 2..2**N");
   end
`ifdef DECODER_BBM_EN
   if (PRESCALE < 2) begin : g_prescale_chk
      $error("decoder_scan_nxm: PRESCALE must be >= 2 with break-before-make");
   end
`else
   if (PRESCALE < 1) begin : g_prescale_chk
      $error("decoder_scan_nxm: PRESCALE must be >= 1");
   end
`endif

   state_e           state_q, state_d;
   logic [LINES-1:0] out_q, out_d;
   logic [N-1:0]     idx_q, idx_d;
   logic             step_q, step_d;
   logic             err_q, err_d;
   logic             rdy_q, rdy_d;
   logic             run, tc, accept, addr_ok;
`ifdef DECODER_BBM_EN
   logic             pre_tc;
   logic             pend_q, pend_d;
   logic [N-1:0]     paddr_q, paddr_d;
`endif

   assign run     = (state_q == SCAN) && bus.en && (bus.mode == MODE_SCAN);
   assign accept  = bus.in_valid && rdy_q;
   assign addr_ok = (32'(bus.in_addr) < LINES);

   decoder_scan_nxm_scan_prescaler #(
      .PRESCALE (PRESCALE)
   ) u_prescaler (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr    (!run),
      .en     (run),
      .tc     (tc)
`ifdef DECODER_BBM_EN
      ,
      .pre_tc (pre_tc)
`endif
   );

   // Next state and next registered outputs.
   always_comb begin
      state_d = state_q;
      out_d   = out_q;
      idx_d   = idx_q;
      step_d  = 1'b0;
      err_d   = 1'b0;
      rdy_d   = rdy_q;
`ifdef DECODER_BBM_EN
      pend_d  = pend_q;
      paddr_d = paddr_q;
`endif
      if (!bus.en) begin
         state_d = IDLE;
         out_d   = '0;
         idx_d   = '0;
         rdy_d   = 1'b0;
`ifdef DECODER_BBM_EN
         pend_d  = 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_d = BLANK;
               out_d   = '0;
               rdy_d   = 1'b0;
            end
            BLANK: begin
               if (bus.mode == MODE_DIRECT) begin
                  state_d = DIRECT;
                  out_d   = '0;
                  rdy_d   = 1'b1;
               end else begin
                  state_d = SCAN;
                  out_d   = LINES'(1);
                  idx_d   = '0;
                  step_d  = 1'b1;
                  rdy_d   = 1'b0;
               end
            end
            DIRECT: begin
               if (bus.mode == MODE_SCAN) begin
                  state_d = BLANK;
                  out_d   = '0;
                  rdy_d   = 1'b0;
`ifdef DECODER_BBM_EN
                  pend_d  = 1'b0;
               end else if (pend_q) begin
                  out_d   = LINES'(1) << paddr_q;
                  idx_d   = paddr_q;
                  pend_d  = 1'b0;
                  rdy_d   = 1'b1;
`endif
               end else if (accept) begin
                  if (!addr_ok) begin
                     err_d = 1'b1;
                  end
`ifdef DECODER_BBM_EN
                  // A different line while one is lit: blank first, drive it next cycle.
                  else if ((out_q != '0) && (bus.in_addr != idx_q)) begin
                     out_d   = '0;
                     pend_d  = 1'b1;
                     paddr_d = bus.in_addr;
                     rdy_d   = 1'b0;
                  end
`endif
                  else begin
                     out_d = LINES'(1) << bus.in_addr;
                     idx_d = bus.in_addr;
                  end
               end
            end
            SCAN: begin
               if (bus.mode == MODE_DIRECT) begin
                  state_d = BLANK;
                  out_d   = '0;
               end else if (tc) begin
                  idx_d  = (idx_q == LAST_IDX) ? '0 : idx_q + N'(1);
                  out_d  = LINES'(1) << idx_d;
                  step_d = 1'b1;
               end
`ifdef DECODER_BBM_EN
               else if (pre_tc) begin
                  out_d = '0;
               end
`endif
            end
            default: begin
               state_d = IDLE;
               out_d   = '0;
               rdy_d   = 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         out_q   <= '0;
         idx_q   <= '0;
         step_q  <= 1'b0;
         err_q   <= 1'b0;
         rdy_q   <= 1'b0;
`ifdef DECODER_BBM_EN
         pend_q  <= 1'b0;
         paddr_q <= '0;
`endif
      end else begin
         state_q <= state_d;
         out_q   <= out_d;
         idx_q   <= idx_d;
         step_q  <= step_d;
         err_q   <= err_d;
         rdy_q   <= rdy_d;
`ifdef DECODER_BBM_EN
         pend_q  <= pend_d;
         paddr_q <= paddr_d;
`endif
      end
   end

   assign bus.out        = out_q;
   assign bus.active_idx = idx_q;
   assign bus.step       = step_q;
   assign bus.err        = err_q;
   assign bus.in_ready   = rdy_q;

endmodule
